comp_mult_job_sched: RTL and testbench
======================================

// Module: comp_mult_job_sched
// PURPOSE
//  Job scheduler in front of the comp_mult_top register file. Buffers complex-multiply job
//  descriptors (op1/op2/result base address, number of ops) in a small FIFO and, for each job, programs
//  RF regs 0..4 over the rf_* bus, polls the done status bit and issues the next job.
//  It replaces hand-driven RF programming by the testbench/host. The job queue is the only RF master.
// PARAMETERS
//  SYS_AW     16    system address width (rf_addr, base addresses)
//  REG_DW     32    register file data width (rf_cfg, rf_sts)
//  RF_BADDR   0     RF base address: +0 OP1, +1 OP2, +2 RES, +3 NR_OP, +4 CTRL (write 1 = start), +5 STATUS
//  FIFO_DEPTH 4     job FIFO entries, power of 2, >=2
//  TIMEOUT    65535 max GUARD+POLL cycles per job; 0 disables timeout
// PORTS
//  clk          in   1                    system clock, rising edge
//  sw_rst       in   1                    synchronous reset, active high
//  job_valid    in   1                    job descriptor valid
//  job_ready    out  1                    FIFO can accept (= !full)
//  job_op1_ba   in   SYS_AW               operand 1 base address
//  job_op2_ba   in   SYS_AW               operand 2 base address
//  job_res_ba   in   SYS_AW               result base address
//  job_nr_op    in   16                   number of complex operations
//  rf_addr      out  SYS_AW               RF address
//  rf_wr        out  1                    RF write enable (0 = read)
//  rf_cfg       out  REG_DW               RF write data
//  rf_sts       in   REG_DW               RF read data, valid 1 cycle after rf_addr (bit0 = done)
//  busy         out  1                    FSM not in IDLE or FIFO not empty
//  done_pulse   out  1                    1-cycle pulse per completed job
//  err_timeout  out  1                    sticky: a job timed out
//  jobs_done    out  16                   completed-job counter, wraps 0xFFFF->0
//  fifo_level   out  $clog2(FIFO_DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//  Reset (sw_rst=1 at clk edge): FIFO flushed, FSM->IDLE, job_ready=1, rf_wr=0, rf_addr=0, rf_cfg=0,
//   busy=0, done_pulse=0, err_timeout=0, jobs_done=0, fifo_level=0. Mid-job reset abandons the job;
//   the multiplier is reset by the same sw_rst.
//  FIFO: push on job_valid&job_ready; job_ready=!full (a push is refused when full, even on a same-cycle pop).
//   Pop only in IDLE when not empty; a job pushed at edge T is visible at T+1.
//  FSM (all outputs registered):
//   IDLE   : if !empty -> pop, latch descriptor; nr_op==0 -> DONE, else -> WR_OP1
//   WR_OP1 : rf_wr=1 addr=BADDR+0 cfg=op1_ba (zero-ext) -> WR_OP2
//   WR_OP2 : addr +1 cfg=op2_ba -> WR_RES;  WR_RES: addr +2 cfg=res_ba -> WR_NOP
//   WR_NOP : addr +3 cfg=nr_op -> WR_START; WR_START: addr +4 cfg=1 -> GUARD
//   GUARD  : rf_wr=0, addr=BADDR+5, 2 cycles (done bit cleared by start write) -> POLL
//   POLL   : rf_wr=0 addr=BADDR+5; sample rf_sts[0] every cycle from the 2nd POLL cycle on;
//            rf_sts[0]=1 -> DONE
//   DONE   : done_pulse=1, jobs_done+=1 -> IDLE
//   Timeout: counter cleared at WR_START, counts in GUARD/POLL; if TIMEOUT!=0 and count==TIMEOUT
//            -> err_timeout=1 (sticky), no done_pulse, no count, FSM -> IDLE (next job proceeds).
//  Outside the WR_* states, rf_wr=0 and rf_cfg=0.
//  Latency: push into empty idle FIFO at edge T -> rf_wr=1 (OP1) in cycle T+2..T+6 -> POLL from T+9.
//  Back-to-back jobs: IDLE takes exactly 1 cycle between DONE and WR_OP1.
// TESTING
//  1 reset: drive sw_rst 5 cycles -> all outputs at reset values, job_ready=1.
//  2 single job op1=100 op2=200 res=300 nr=10 -> RF writes (0,100)(1,200)(2,300)(3,10)(4,1) on 5
//    consecutive cycles; model done after 40 cycles -> one done_pulse, jobs_done=1.
//  3 push 5 jobs with FIFO_DEPTH=4 while the first job runs -> job_ready=0 when level=4; all 5
//    complete in order, jobs_done=5.
//  4 job with nr_op=0 -> no RF writes, done_pulse 2 cycles after push, jobs_done+1.
//  5 TIMEOUT=50, rf_sts[0] held 0 -> err_timeout=1 after 50 GUARD/POLL cycles, no done_pulse;
//    next job still runs.
//  6 sw_rst asserted in POLL with 2 jobs queued -> next cycle rf_wr=0, fifo_level=0, busy=0, jobs_done=0.

Source files
------------

// File: rtl/comp_mult_job_sched.sv
// Job scheduler for the comp_mult register file: queues job descriptors, programs
// RF regs 0..4 for each job, polls the done bit and retires the job.
module comp_mult_job_sched #(
    parameter int SYS_AW     = 16,
    parameter int REG_DW     = 32,
    parameter int RF_BADDR   = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                          clk,
    input  logic                          sw_rst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [SYS_AW-1:0]             job_op1_ba,
    input  logic [SYS_AW-1:0]             job_op2_ba,
    input  logic [SYS_AW-1:0]             job_res_ba,
    input  logic [15:0]                   job_nr_op,
    output logic [SYS_AW-1:0]             rf_addr,
    output logic                          rf_wr,
    output logic [REG_DW-1:0]             rf_cfg,
    input  logic [REG_DW-1:0]             rf_sts,
    output logic                          busy,
    output logic                          done_pulse,
    output logic                          err_timeout,
    output logic [15:0]                   jobs_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

    typedef struct packed {
        logic [SYS_AW-1:0] op1;
        logic [SYS_AW-1:0] op2;
        logic [SYS_AW-1:0] res;
        logic [15:0]       nr;
    } job_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_OP1, S_WR_OP2, S_WR_RES, S_WR_NOP,
        S_WR_START, S_GUARD, S_POLL, S_DONE
    } state_t;

    job_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_count;

    state_t        r_state;
    job_t          r_job;
    logic          r_guard;
    logic          r_poll_first;
    logic [31:0]   r_to_cnt;
    logic [SYS_AW-1:0] r_rf_addr;
    logic          r_rf_wr;
    logic [REG_DW-1:0] r_rf_cfg;
    logic          r_done_pulse;
    logic          r_err_timeout;
    logic [15:0]   r_jobs_done;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_to_hit;
    logic          w_unused;
    job_t          w_head;

    function automatic logic [SYS_AW-1:0] rf_at(input int off);
        return SYS_AW'(RF_BADDR + off);
    endfunction

    assign w_full   = (r_count == LW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = job_valid & ~w_full;
    assign w_pop    = (r_state == S_IDLE) & ~w_empty;
    assign w_head   = r_mem[r_rptr];
    // Hit on the GUARD/POLL cycle that brings the count up to TIMEOUT.
    assign w_to_hit = (TIMEOUT != 0) && ((r_to_cnt + 32'd1) == TO_LIM);
    assign w_unused = ^rf_sts[REG_DW-1:1];

    assign job_ready   = ~w_full;
    assign fifo_level  = r_count;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign rf_addr     = r_rf_addr;
    assign rf_wr       = r_rf_wr;
    assign rf_cfg      = r_rf_cfg;
    assign done_pulse  = r_done_pulse;
    assign err_timeout = r_err_timeout;
    assign jobs_done   = r_jobs_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{op1: job_op1_ba, op2: job_op2_ba, res: job_res_ba, nr: job_nr_op};
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs are loaded on the edge that enters a state, so they always match r_state.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state       <= S_IDLE;
            r_job         <= '0;
            r_guard       <= 1'b0;
            r_poll_first  <= 1'b0;
            r_to_cnt      <= '0;
            r_rf_addr     <= '0;
            r_rf_wr       <= 1'b0;
            r_rf_cfg      <= '0;
            r_done_pulse  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_jobs_done   <= '0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_job <= w_head;
                        if (w_head.nr == 16'd0) begin
                            r_state      <= S_DONE;
                            r_done_pulse <= 1'b1;
                            r_jobs_done  <= r_jobs_done + 16'd1;
                        end else begin
                            r_state   <= S_WR_OP1;
                            r_rf_wr   <= 1'b1;
                            r_rf_addr <= rf_at(0);
                            r_rf_cfg  <= REG_DW'(w_head.op1);
                        end
                    end
                end
                S_WR_OP1: begin
                    r_state   <= S_WR_OP2;
                    r_rf_addr <= rf_at(1);
                    r_rf_cfg  <= REG_DW'(r_job.op2);
                end
                S_WR_OP2: begin
                    r_state   <= S_WR_RES;
                    r_rf_addr <= rf_at(2);
                    r_rf_cfg  <= REG_DW'(r_job.res);
                end
                S_WR_RES: begin
                    r_state   <= S_WR_NOP;
                    r_rf_addr <= rf_at(3);
                    r_rf_cfg  <= REG_DW'(r_job.nr);
                end
                S_WR_NOP: begin
                    r_state   <= S_WR_START;
                    r_rf_addr <= rf_at(4);
                    r_rf_cfg  <= REG_DW'(1);
                    r_to_cnt  <= '0;
                end
                S_WR_START: begin
                    r_state   <= S_GUARD;
                    r_rf_wr   <= 1'b0;
                    r_rf_cfg  <= '0;
                    r_rf_addr <= rf_at(5);
                    r_guard   <= 1'b0;
                end
                S_GUARD: begin
                    r_to_cnt <= r_to_cnt + 32'd1;
                    r_guard  <= 1'b1;
                    if (w_to_hit) begin
                        r_state       <= S_IDLE;
                        r_err_timeout <= 1'b1;
                    end else if (r_guard) begin
                        r_state      <= S_POLL;
                        r_poll_first <= 1'b1;
                    end
                end
                S_POLL: begin
                    r_to_cnt     <= r_to_cnt + 32'd1;
                    r_poll_first <= 1'b0;
                    if (!r_poll_first && rf_sts[0]) begin
                        r_state      <= S_DONE;
                        r_done_pulse <= 1'b1;
                        r_jobs_done  <= r_jobs_done + 16'd1;
                    end else if (w_to_hit) begin
                        r_state       <= S_IDLE;
                        r_err_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_mult_job_sched.sv
// Bench for comp_mult_job_sched: randomized jobs against a queue-based job model and
// a behavioural RF/multiplier peripheral that raises done a chosen number of cycles after start.
module tb_comp_mult_job_sched;

    logic        clk = 1'b0;
    logic        sw_rst;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_op1_ba;
    logic [15:0] job_op2_ba;
    logic [15:0] job_res_ba;
    logic [15:0] job_nr_op;
    logic [15:0] rf_addr;
    logic        rf_wr;
    logic [31:0] rf_cfg;
    logic [31:0] rf_sts;
    logic        busy;
    logic        done_pulse;
    logic        err_timeout;
    logic [15:0] jobs_done;
    logic [2:0]  fifo_level;

    logic [47:0] exp_q[$];
    logic [15:0] exp_done_q[$];
    int          lat_q[$];
    logic [15:0] exp_jobs;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        m_done;
    int          m_cnt;
    int          m_lat;

    always #5 clk = ~clk;

    comp_mult_job_sched #(
        .SYS_AW(16), .REG_DW(32), .RF_BADDR(0), .FIFO_DEPTH(4), .TIMEOUT(50)
    ) dut (
        .clk(clk), .sw_rst(sw_rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_op1_ba(job_op1_ba), .job_op2_ba(job_op2_ba), .job_res_ba(job_res_ba),
        .job_nr_op(job_nr_op), .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_cfg(rf_cfg),
        .rf_sts(rf_sts), .busy(busy), .done_pulse(done_pulse), .err_timeout(err_timeout),
        .jobs_done(jobs_done), .fifo_level(fifo_level)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    // RF peripheral: start write clears done; done rises lat cycles later (lat 0 = never).
    always @(posedge clk) begin
        if (sw_rst) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
            rf_sts <= 32'd0;
        end else begin
            if (rf_wr === 1'b1 && rf_addr == 16'd4 && rf_cfg == 32'd1) begin
                if (lat_q.size() == 0) begin
                    fail_now("rf_unexpected_start");
                    m_lat = 0;
                end else begin
                    m_lat = lat_q.pop_front();
                end
                m_done <= 1'b0;
                m_cnt  <= m_lat;
            end else if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_cnt  <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
            rf_sts <= (rf_addr == 16'd5) ? {31'd0, m_done} : 32'd0;
        end
    end

    // Monitor: every RF write and every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (sw_rst === 1'b0) begin
            if (rf_wr === 1'b1) begin
                if (exp_q.size() == 0) fail_now("rf_write_unexpected");
                else check("rf_write", {16'd0, rf_addr, rf_cfg}, {16'd0, exp_q.pop_front()});
            end
            if (done_pulse === 1'b1) begin
                if (exp_done_q.size() == 0) fail_now("done_pulse_unexpected");
                else check("jobs_done_at_pulse", {48'd0, jobs_done}, {48'd0, exp_done_q.pop_front()});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_job(input logic [15:0] op1, input logic [15:0] op2,
                            input logic [15:0] res, input logic [15:0] nr, input int lat);
        int w;
        w = 0;
        job_valid  = 1'b1;
        job_op1_ba = op1;
        job_op2_ba = op2;
        job_res_ba = res;
        job_nr_op  = nr;
        while (!job_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!job_ready) begin
            fail_now("push_ready_wait");
            job_valid = 1'b0;
            return;
        end
        if (nr != 16'd0) begin
            exp_q.push_back({16'd0, 16'd0, op1});
            exp_q.push_back({16'd1, 16'd0, op2});
            exp_q.push_back({16'd2, 16'd0, res});
            exp_q.push_back({16'd3, 16'd0, nr});
            exp_q.push_back({16'd4, 32'd1});
            lat_q.push_back(lat);
        end
        if (nr == 16'd0 || lat != 0) begin
            exp_jobs = exp_jobs + 16'd1;
            exp_done_q.push_back(exp_jobs);
        end
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (!(exp_q.size() == 0 && exp_done_q.size() == 0 && !busy) && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (!(exp_q.size() == 0 && exp_done_q.size() == 0 && !busy)) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end within 20000 cycles");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] nr;
        int lat;
        sw_rst = 1'b1;
        job_valid = 1'b0;
        job_op1_ba = '0;
        job_op2_ba = '0;
        job_res_ba = '0;
        job_nr_op  = '0;
        exp_jobs   = '0;

        // Reset values after 5 reset edges
        repeat (5) @(negedge clk);
        check("rst_job_ready", {63'd0, job_ready}, 64'd1);
        check("rst_rf_wr", {63'd0, rf_wr}, 64'd0);
        check("rst_rf_addr", {48'd0, rf_addr}, 64'd0);
        check("rst_rf_cfg", {32'd0, rf_cfg}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done_pulse", {63'd0, done_pulse}, 64'd0);
        check("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
        check("rst_jobs_done", {48'd0, jobs_done}, 64'd0);
        check("rst_fifo_level", {61'd0, fifo_level}, 64'd0);
        sw_rst = 1'b0;
        @(negedge clk);

        // Single job: five consecutive RF writes starting 2 cycles after the push
        push_job(16'd100, 16'd200, 16'd300, 16'd10, 40);
        check("busy_after_push", {63'd0, busy}, 64'd1);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check("single_wr_window", {63'd0, rf_wr}, (j <= 5) ? 64'd1 : 64'd0);
        end
        wait_drain();
        check("single_jobs_done", {48'd0, jobs_done}, 64'd1);

        // Five jobs while the first runs: FIFO fills to 4
        for (int i = 0; i < 5; i++)
            push_job(16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom_range(1, 50)), $urandom_range(5, 40));
        check("full_level", {61'd0, fifo_level}, 64'd4);
        check("full_job_ready", {63'd0, job_ready}, 64'd0);
        c = 0;
        while (done_pulse !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (done_pulse !== 1'b1) fail_now("b2b_done_wait");
        @(negedge clk);
        check("b2b_idle_gap", {63'd0, rf_wr}, 64'd0);
        @(negedge clk);
        check("b2b_next_op1", {47'd0, rf_wr, rf_addr}, {47'd0, 1'b1, 16'd0});
        wait_drain();
        check("fill_jobs_done", {48'd0, jobs_done}, 64'd6);

        // nr_op = 0: no RF writes, done_pulse in the second cycle after the push
        push_job(16'($urandom), 16'($urandom), 16'($urandom), 16'd0, 0);
        check("zero_nr_no_pulse_yet", {62'd0, done_pulse, rf_wr}, 64'd0);
        @(negedge clk);
        check("zero_nr_pulse", {62'd0, done_pulse, rf_wr}, 64'd2);
        check("zero_nr_jobs_done", {48'd0, jobs_done}, 64'd7);
        @(negedge clk);
        check("zero_nr_pulse_width", {63'd0, done_pulse}, 64'd0);
        wait_drain();

        // Timeout: done never rises; err after exactly 50 GUARD/POLL cycles
        push_job(16'd1, 16'd2, 16'd3, 16'd5, 0);
        for (int j = 1; j <= 56; j++) begin
            @(negedge clk);
            if (j == 55) check("timeout_not_yet", {63'd0, err_timeout}, 64'd0);
            if (j == 56) check("timeout_err", {63'd0, err_timeout}, 64'd1);
        end
        check("timeout_back_idle", {63'd0, busy}, 64'd0);
        push_job(16'd7, 16'd8, 16'd9, 16'd3, 10);
        wait_drain();
        check("after_timeout_jobs_done", {48'd0, jobs_done}, 64'd8);
        check("timeout_sticky", {63'd0, err_timeout}, 64'd1);

        // Randomized jobs with random gaps, zero-op jobs and occasional timeouts
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            nr  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 40);
            push_job(16'($urandom), 16'($urandom), 16'($urandom), nr, lat);
        end
        wait_drain();
        check("random_jobs_done", {48'd0, jobs_done}, {48'd0, exp_jobs});

        // Reset while polling with two jobs queued
        push_job(16'd11, 16'd12, 16'd13, 16'd4, 40);
        push_job(16'd21, 16'd22, 16'd23, 16'd4, 40);
        push_job(16'd31, 16'd32, 16'd33, 16'd4, 40);
        repeat (8) @(negedge clk);
        check("pre_reset_level", {61'd0, fifo_level}, 64'd2);
        exp_q.delete();
        exp_done_q.delete();
        lat_q.delete();
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        check("midrst_rf_wr", {63'd0, rf_wr}, 64'd0);
        check("midrst_fifo_level", {61'd0, fifo_level}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_jobs_done", {48'd0, jobs_done}, 64'd0);
        check("midrst_err", {63'd0, err_timeout}, 64'd0);
        check("midrst_job_ready", {63'd0, job_ready}, 64'd1);
        repeat (5) @(negedge clk);
        exp_jobs = '0;
        push_job(16'd41, 16'd42, 16'd43, 16'd2, 12);
        wait_drain();
        check("post_reset_jobs_done", {48'd0, jobs_done}, 64'd1);

        check("queues_empty", {32'd0, 32'(exp_q.size() + exp_done_q.size() + lat_q.size())}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
